// File: rtl/rom_arbiter.sv
// ============================================================================
//  Module   : rom_arbiter
//  Purpose  : Two-requester arbiter in front of a shared single-cycle ROM.
//             Define ROM_ARBITER_RR_EN for round-robin contention handling,
//             otherwise requester 0 has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
   parameter int MEM_ADDR  = 4,
   parameter int MEM_EXTRA = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req0,
   input  logic [MEM_ADDR:0]              addr0,
   input  logic [MEM_EXTRA-1:0]           extra0,
   input  logic [MEM_ADDR:0]              lower0,
   input  logic [MEM_ADDR:0]              upper0,
   input  logic                           req1,
   input  logic [MEM_ADDR:0]              addr1,
   input  logic [MEM_EXTRA-1:0]           extra1,
   input  logic [MEM_ADDR:0]              lower1,
   input  logic [MEM_ADDR:0]              upper1,
   output logic                           ack0,
   output logic [(2**MEM_EXTRA)*8-1:0]    data0,
   output logic                           error0,
   output logic                           ack1,
   output logic [(2**MEM_EXTRA)*8-1:0]    data1,
   output logic                           error1,
   output logic [MEM_ADDR:0]              mem_addr,
   output logic [MEM_EXTRA-1:0]           mem_extra,
   output logic [MEM_ADDR:0]              mem_lower_bound,
   output logic [MEM_ADDR:0]              mem_upper_bound,
   input  logic [(2**MEM_EXTRA)*8-1:0]    mem_data,
   input  logic                           mem_error,
   output logic                           busy
);

   localparam int DATA_W = (2**MEM_EXTRA)*8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic [DATA_W-1:0]    data0_q, data0_d;
   logic [DATA_W-1:0]    data1_q, data1_d;
   logic                 error0_q, error0_d;
   logic                 error1_q, error1_d;
   logic [MEM_ADDR:0]    maddr_q, maddr_d;
   logic [MEM_EXTRA-1:0] mextra_q, mextra_d;
   logic [MEM_ADDR:0]    mlower_q, mlower_d;
   logic [MEM_ADDR:0]    mupper_q, mupper_d;
   logic                 pick;

`ifdef ROM_ARBITER_RR_EN
   logic                 last_q, last_d;

   // Under contention the requester that was not served last goes next.
   always_comb begin
      pick   = (req0 && req1) ? ~last_q : req1;
      last_d = last_q;
      if ((state_q == S_IDLE) && (req0 || req1)) begin
         last_d = pick;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      pick = ~req0;
   end
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      data0_d  = data0_q;
      data1_d  = data1_q;
      error0_d = error0_q;
      error1_d = error1_q;
      maddr_d  = maddr_q;
      mextra_d = mextra_q;
      mlower_d = mlower_q;
      mupper_d = mupper_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               grant_d  = pick;
               maddr_d  = pick ? addr1  : addr0;
               mextra_d = pick ? extra1 : extra0;
               mlower_d = pick ? lower1 : lower0;
               mupper_d = pick ? upper1 : upper0;
               state_d  = S_READ;
            end
         end
         S_READ: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            // ROM result for the address issued at grant is valid now.
            if (grant_q) begin
               data1_d  = mem_data;
               error1_d = mem_error;
               ack1_d   = 1'b1;
            end else begin
               data0_d  = mem_data;
               error0_d = mem_error;
               ack0_d   = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         data0_q  <= '0;
         data1_q  <= '0;
         error0_q <= 1'b0;
         error1_q <= 1'b0;
         maddr_q  <= '0;
         mextra_q <= '0;
         mlower_q <= '0;
         mupper_q <= '1;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         error0_q <= error0_d;
         error1_q <= error1_d;
         maddr_q  <= maddr_d;
         mextra_q <= mextra_d;
         mlower_q <= mlower_d;
         mupper_q <= mupper_d;
      end
   end

   assign ack0            = ack0_q;
   assign ack1            = ack1_q;
   assign data0           = data0_q;
   assign data1           = data1_q;
   assign error0          = error0_q;
   assign error1          = error1_q;
   assign mem_addr        = maddr_q;
   assign mem_extra       = mextra_q;
   assign mem_lower_bound = mlower_q;
   assign mem_upper_bound = mupper_q;
   assign busy            = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
//  Module   : tb_rom_arbiter
//  Purpose  : Self-checking bench for rom_arbiter with a behavioural ROM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

   localparam int MEM_ADDR  = 4;
   localparam int MEM_EXTRA = 4;
   localparam int DW        = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req0, req1;
   logic [4:0]    addr0, lower0, upper0, addr1, lower1, upper1;
   logic [3:0]    extra0, extra1;
   logic          ack0, ack1, error0, error1, busy;
   logic [DW-1:0] data0, data1;
   logic [4:0]    mem_addr, mem_lower_bound, mem_upper_bound;
   logic [3:0]    mem_extra;
   logic [DW-1:0] mem_data = '0;
   logic          mem_error = 1'b0;

   always #5 clk = ~clk;

   rom_arbiter #(.MEM_ADDR(MEM_ADDR), .MEM_EXTRA(MEM_EXTRA)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .extra0(extra0), .lower0(lower0), .upper0(upper0),
      .req1(req1), .addr1(addr1), .extra1(extra1), .lower1(lower1), .upper1(upper1),
      .ack0(ack0), .data0(data0), .error0(error0),
      .ack1(ack1), .data1(data1), .error1(error1),
      .mem_addr(mem_addr), .mem_extra(mem_extra),
      .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
      .mem_data(mem_data), .mem_error(mem_error), .busy(busy)
   );

   function automatic logic [7:0] rom_byte(int a);
      return 8'(a * 29) ^ 8'hA5;
   endfunction

   function automatic logic [DW-1:0] rom_word(int a, int e);
      logic [DW-1:0] w = '0;
      for (int i = 0; i < 16; i++) begin
         if (i <= e) w[8*i +: 8] = rom_byte((a + i) % 32);
      end
      return w;
   endfunction

   // Behavioural ROM: registered read, error when the span leaves the bounds.
   always @(posedge clk) begin
      mem_data  <= rom_word(int'(mem_addr), int'(mem_extra));
      mem_error <= (mem_addr < mem_lower_bound) ||
                   ((int'(mem_addr) + int'(mem_extra)) > int'(mem_upper_bound));
   end

   typedef struct {
      int            who;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   typedef struct {
      logic       r0, r1;
      logic [4:0] a0; logic [3:0] e0; logic [4:0] l0, u0;
      logic [4:0] a1; logic [3:0] e1; logic [4:0] l1, u1;
      logic       exp_err;
   } vec_t;

   exp_t          sb[$];
   vec_t          vecs[8];
   int            passed = 0;
   int            total = 0;
   logic [DW-1:0] m_data[2];
   logic          m_err[2];
   int            last_grant = 1;
   exp_t          e_pop;
   int            who;

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int arb(logic r0, logic r1);
`ifdef ROM_ARBITER_RR_EN
      if (r0 && r1) return 1 - last_grant;
`else
      if (r0 && r1) return 0;
`endif
      return r0 ? 0 : 1;
   endfunction

   function automatic vec_t mk(logic r0, logic r1, logic [4:0] a0, logic [3:0] e0,
                               logic [4:0] l0, logic [4:0] u0, logic [4:0] a1,
                               logic [3:0] e1, logic [4:0] l1, logic [4:0] u1,
                               logic exp_err);
      vec_t v;
      v.r0 = r0; v.r1 = r1;
      v.a0 = a0; v.e0 = e0; v.l0 = l0; v.u0 = u0;
      v.a1 = a1; v.e1 = e1; v.l1 = l1; v.u1 = u1;
      v.exp_err = exp_err;
      return v;
   endfunction

   // Completion monitor: pops the scoreboard on every ack pulse.
   always @(negedge clk) begin
      if (reset && (ack0 || ack1)) begin
         check("ack_exclusive", DW'(ack0 & ack1), DW'(0));
         who = ack1 ? 1 : 0;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_ack: ack0=%b ack1=%b expected no ack", ack0, ack1);
         end else begin
            e_pop = sb.pop_front();
            check("ack_who", DW'(who), DW'(e_pop.who));
            check("data", (e_pop.who == 1) ? data1 : data0, e_pop.data);
            check("error", DW'((e_pop.who == 1) ? error1 : error0), DW'(e_pop.err));
            check("other_data_held", (e_pop.who == 1) ? data0 : data1, m_data[1 - e_pop.who]);
            check("other_error_held", DW'((e_pop.who == 1) ? error0 : error1),
                  DW'(m_err[1 - e_pop.who]));
            m_data[e_pop.who] = e_pop.data;
            m_err[e_pop.who]  = e_pop.err;
         end
      end
   end

   task automatic check_reset_state();
      check("rst_ack0", DW'(ack0), DW'(0));
      check("rst_ack1", DW'(ack1), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_data0", data0, '0);
      check("rst_data1", data1, '0);
      check("rst_error0", DW'(error0), DW'(0));
      check("rst_error1", DW'(error1), DW'(0));
      check("rst_mem_addr", DW'(mem_addr), DW'(0));
      check("rst_mem_extra", DW'(mem_extra), DW'(0));
      check("rst_mem_lower", DW'(mem_lower_bound), DW'(0));
      check("rst_mem_upper", DW'(mem_upper_bound), DW'(5'h1F));
   endtask

   task automatic drive(vec_t v);
      req0 = v.r0; addr0 = v.a0; extra0 = v.e0; lower0 = v.l0; upper0 = v.u0;
      req1 = v.r1; addr1 = v.a1; extra1 = v.e1; lower1 = v.l1; upper1 = v.u1;
   endtask

   // Single grant with a one-cycle request pulse, then the latency window.
   task automatic apply(vec_t v);
      int   win;
      exp_t e;
      @(negedge clk);
      drive(v);
      win = arb(v.r0, v.r1);
      last_grant = win;
      e.who  = win;
      e.data = win ? rom_word(int'(v.a1), int'(v.e1)) : rom_word(int'(v.a0), int'(v.e0));
      e.err  = v.exp_err;
      sb.push_back(e);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      check("busy_read", DW'(busy), DW'(1));
      check("no_early_ack", DW'(ack0 | ack1), DW'(0));
      @(posedge clk); #1;
      check("busy_resp", DW'(busy), DW'(1));
      check("no_early_ack", DW'(ack0 | ack1), DW'(0));
      @(posedge clk); #1;
      check("busy_done", DW'(busy), DW'(0));
      check("ack_latency", DW'(win ? ack1 : ack0), DW'(1));
      @(posedge clk); #1;
      check("ack_one_cycle", DW'(ack0 | ack1), DW'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   w;
      m_data[0] = '0; m_data[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
      drive(mk(0, 0, 5'h00, 4'h0, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 0));

      vecs[0] = mk(1, 0, 5'h03, 4'h0, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 0);
      vecs[1] = mk(0, 1, 5'h00, 4'h0, 5'h00, 5'h1F, 5'h10, 4'h0, 5'h00, 5'h0F, 1);
      vecs[2] = mk(0, 1, 5'h00, 4'h0, 5'h00, 5'h1F, 5'h07, 4'h0, 5'h00, 5'h1F, 0);
      vecs[3] = mk(1, 0, 5'h1E, 4'h3, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 1);
      vecs[4] = mk(1, 0, 5'h02, 4'h0, 5'h04, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 1);
      vecs[5] = mk(1, 1, 5'h08, 4'h1, 5'h00, 5'h1F, 5'h09, 4'h2, 5'h00, 5'h1F, 0);
      vecs[6] = mk(0, 1, 5'h00, 4'h0, 5'h00, 5'h1F, 5'h1F, 4'h0, 5'h00, 5'h1F, 0);
      vecs[7] = mk(1, 0, 5'h00, 4'hF, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 0);

      #12;
      check_reset_state();
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) apply(vecs[i]);

      // Contention held for six edges: two grants at 3-cycle spacing.
      @(negedge clk);
      drive(mk(1, 1, 5'h0A, 4'h0, 5'h00, 5'h1F, 5'h0B, 4'h0, 5'h00, 5'h1F, 0));
      for (int k = 0; k < 2; k++) begin
         w = arb(1'b1, 1'b1);
         last_grant = w;
         e.who = w;
         e.data = w ? rom_word(11, 0) : rom_word(10, 0);
         e.err = 1'b0;
         sb.push_back(e);
      end
      repeat (6) @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge clk);
      check("contention_drained", DW'(sb.size()), DW'(0));

      // Reset asserted while the ROM read is in flight.
      @(negedge clk);
      drive(mk(1, 0, 5'h04, 4'h0, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 0));
      e.who = 0; e.data = rom_word(4, 0); e.err = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      reset = 1'b0;
      req0 = 1'b0;
      #1;
      check_reset_state();
      sb.delete();
      m_data[0] = '0; m_data[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
      last_grant = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ack_in_reset", DW'(ack0 | ack1), DW'(0));
      end
      reset = 1'b1;
      apply(mk(1, 0, 5'h01, 4'h0, 5'h00, 5'h1F, 5'h00, 4'h0, 5'h00, 5'h1F, 0));

      repeat (3) @(negedge clk);
      check("sb_empty", DW'(sb.size()), DW'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
